ram_sim_master: RTL and testbench

- Initiator-side controller for the 16-entry x 25-bit simulation RAMs (ref/act image stores). It drives their addr_wr/addr_rd/in/wr_enm port.
- LOAD operation: takes a valid/ready input stream and writes it into consecutive RAM entries starting at entry 0.
- DUMP operation: reads consecutive entries back out on a valid/ready output stream.
- One instance per RAM; sits between the stream fabric and the RAM.

---
 rtl/ram_sim_master_pkg.sv | 23 ++
 rtl/ram_sim_master.sv | 122 ++++++++++++
 tb/tb_ram_sim_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_sim_master_pkg.sv
// Shared constants, FSM state type and length clamp for ram_sim_master.
// Sizes match the 16-entry x 25-bit simulation RAMs.
// Nothing here holds state.
package ram_sim_master_pkg;

  localparam int DW    = 25;  // RAM data width
  localparam int AW    = 11;  // RAM address port width
  localparam int IW    = 4;   // index bits actually used
  localparam int DEPTH = 16;  // 2**IW entries
  localparam int LW    = 5;   // width of the len command field

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2
  } state_t;

  // Lengths past the RAM depth are treated as a full-RAM transfer.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    return (l > LW'(DEPTH)) ? LW'(DEPTH) : l;
  endfunction

endpackage

// File: rtl/ram_sim_master.sv
// Initiator for a 16x25 sim RAM: LOAD streams s_* into RAM[0..n-1], DUMP streams RAM[0..n-1] out on m_*.
// Latency: zero; RAM write on the s handshake edge, async RAM read drives m_data combinationally; done 1 cycle after last beat.
// Backpressure: s_valid low or m_ready low stalls indefinitely; s_ready only high in LOAD, m_valid only high in DUMP.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   cmd_load, cmd_dump   start pulses (sampled in IDLE only, LOAD wins), len = word count (clamped to 16)
//   busy, done           operation in progress / one-cycle completion pulse
//   s_valid/s_data/s_ready   input stream (LOAD)
//   m_valid/m_data/m_ready   output stream (DUMP)
//   addr_wr, ram_in, wr_enm  RAM write port
//   addr_rd, ram_out         RAM asynchronous read port
module ram_sim_master
  import ram_sim_master_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_load,
  input  logic          cmd_dump,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [AW-1:0] addr_wr,
  output logic [DW-1:0] ram_in,
  output logic          wr_enm,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] ram_out
);

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic          done_nxt;
  logic [LW-1:0] len_eff;

  assign len_eff = clamp_len(len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    s_ready   = 1'b0;
    wr_enm    = 1'b0;
    ram_in    = '0;
    addr_wr   = '0;
    m_valid   = 1'b0;
    addr_rd   = '0;

    case (state)
      IDLE: begin
        if (cmd_load || cmd_dump) begin
          idx_nxt = '0;
          cnt_nxt = len_eff;
          // A zero-length command completes immediately without leaving IDLE.
          if (len_eff == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = cmd_load ? LOAD : DUMP;
          end
        end
      end

      LOAD: begin
        s_ready = 1'b1;
        wr_enm  = s_valid;
        ram_in  = s_data;
        addr_wr = {{(AW-IW){1'b0}}, idx};
        if (s_valid) begin
          idx_nxt = idx + 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == LW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      DUMP: begin
        m_valid = 1'b1;
        addr_rd = {{(AW-IW){1'b0}}, idx};
        if (m_ready) begin
          idx_nxt = idx + 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == LW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy   = (state != IDLE);
  // Read data passes straight through; idx holds while stalled, so it stays stable.
  assign m_data = ram_out;

endmodule

// File: tb/tb_ram_sim_master.sv
module tb_ram_sim_master;
  import ram_sim_master_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_load = 1'b0, cmd_dump = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [AW-1:0] addr_wr, addr_rd;
  logic [DW-1:0] ram_in, ram_out;
  logic          wr_enm;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int done_mark;

  // Simulation RAM model: sync write, async read, no reset.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (wr_enm) mem[addr_wr[IW-1:0]] <= ram_in;
  assign ram_out = mem[addr_rd[IW-1:0]];

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  ram_sim_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_load(cmd_load), .cmd_dump(cmd_dump), .len(len),
    .busy(busy), .done(done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .addr_wr(addr_wr),
    .ram_in(ram_in), .wr_enm(wr_enm), .addr_rd(addr_rd), .ram_out(ram_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 25'h0ABC000 + DW'(i);

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_wr_enm", 32'(wr_enm), 0);
    chk("rst_addr_wr", 32'(addr_wr), 0);
    chk("rst_addr_rd", 32'(addr_rd), 0);
    chk("rst_ram_in", 32'(ram_in), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // LOAD len=4 with s_valid held high
    done_mark = done_cnt;
    cmd_load = 1'b1; len = 5'd4;
    step();
    cmd_load = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 25'h1000001 + DW'(k);
      #1;
      chk("ld4_busy", 32'(busy), 1);
      chk("ld4_wr_enm", 32'(wr_enm), 1);
      chk("ld4_addr_wr", 32'(addr_wr), 32'(k));
      chk("ld4_ram_in", 32'(ram_in), 32'h1000001 + 32'(k));
      chk("ld4_done_early", 32'(done), 0);
      step();
    end
    s_valid = 1'b0;
    #1;
    chk("ld4_done", 32'(done), 1);
    chk("ld4_busy_after", 32'(busy), 0);
    chk("ld4_wr_enm_after", 32'(wr_enm), 0);
    step();
    chk("ld4_done_clear", 32'(done), 0);
    for (int k = 0; k < 4; k++) chk("ld4_mem", 32'(mem[k]), 32'h1000001 + 32'(k));
    chk("ld4_mem4_kept", 32'(mem[4]), 32'h0ABC004);
    chk("ld4_done_count", 32'(done_cnt - done_mark), 1);

    // DUMP len=4 with m_ready alternating 0,1 (stall then accept per word)
    done_mark = done_cnt;
    cmd_dump = 1'b1; len = 5'd4;
    step();
    cmd_dump = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_ready = 1'b0;
      #1;
      chk("dm4_m_valid", 32'(m_valid), 1);
      chk("dm4_addr_rd_stall", 32'(addr_rd), 32'(k));
      chk("dm4_data_stall", 32'(m_data), 32'h1000001 + 32'(k));
      step();
      m_ready = 1'b1;
      #1;
      chk("dm4_data_hs", 32'(m_data), 32'h1000001 + 32'(k));
      chk("dm4_s_ready", 32'(s_ready), 0);
      step();
    end
    m_ready = 1'b0;
    #1;
    chk("dm4_done", 32'(done), 1);
    chk("dm4_m_valid_after", 32'(m_valid), 0);
    chk("dm4_addr_rd_after", 32'(addr_rd), 0);
    step();
    chk("dm4_done_count", 32'(done_cnt - done_mark), 1);

    // LOAD len=20 clamps to 16 entries
    done_mark = done_cnt;
    cmd_load = 1'b1; len = 5'd20;
    step();
    cmd_load = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_data = 25'h0100000 + DW'(k);
      #1;
      chk("ld20_wr_enm", 32'(wr_enm), 1);
      chk("ld20_addr_wr", 32'(addr_wr), 32'(k));
      step();
    end
    s_data = 25'h1FFFFFF;
    #1;
    chk("ld20_s_ready_drop", 32'(s_ready), 0);
    chk("ld20_wr_enm_drop", 32'(wr_enm), 0);
    chk("ld20_done", 32'(done), 1);
    step();
    s_valid = 1'b0;
    chk("ld20_mem0_kept", 32'(mem[0]), 32'h0100000);
    chk("ld20_mem15", 32'(mem[15]), 32'h010000F);
    chk("ld20_done_count", 32'(done_cnt - done_mark), 1);

    // DUMP len=0: no transfer, done next cycle
    done_mark = done_cnt;
    cmd_dump = 1'b1; len = 5'd0;
    step();
    cmd_dump = 1'b0;
    #1;
    chk("len0_busy", 32'(busy), 0);
    chk("len0_m_valid", 32'(m_valid), 0);
    chk("len0_done", 32'(done), 1);
    step();
    chk("len0_done_clear", 32'(done), 0);
    chk("len0_done_count", 32'(done_cnt - done_mark), 1);

    // LOAD and DUMP together: LOAD wins
    cmd_load = 1'b1; cmd_dump = 1'b1; len = 5'd1;
    step();
    cmd_load = 1'b0; cmd_dump = 1'b0;
    s_valid = 1'b1; s_data = 25'h1ABCDE0;
    #1;
    chk("both_s_ready", 32'(s_ready), 1);
    chk("both_m_valid", 32'(m_valid), 0);
    step();
    s_valid = 1'b0;
    chk("both_done", 32'(done), 1);
    chk("both_mem0", 32'(mem[0]), 32'h1ABCDE0);
    step();

    // Async reset after 2 of 5 load words
    done_mark = done_cnt;
    cmd_load = 1'b1; len = 5'd5;
    step();
    cmd_load = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_data = 25'h1500000 + DW'(k);
      step();
    end
    s_data = 25'h1500002;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s_ready", 32'(s_ready), 0);
    chk("arst_wr_enm", 32'(wr_enm), 0);
    chk("arst_busy", 32'(busy), 0);
    step();
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("arst_no_done", 32'(done_cnt - done_mark), 0);
    chk("arst_mem0", 32'(mem[0]), 32'h1500000);
    chk("arst_mem1", 32'(mem[1]), 32'h1500001);
    for (int k = 2; k < 5; k++) chk("arst_mem_kept", 32'(mem[k]), 32'h0100000 + 32'(k));

    cmd_dump = 1'b1; len = 5'd2;
    step();
    cmd_dump = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("arst_dump_data", 32'(m_data), 32'h1500000 + 32'(k));
      step();
    end
    m_ready = 1'b0;
    chk("arst_dump_done", 32'(done), 1);
    step();

    // cmd_dump while LOAD busy is ignored
    done_mark = done_cnt;
    cmd_load = 1'b1; len = 5'd2;
    step();
    cmd_load = 1'b0; cmd_dump = 1'b1; len = 5'd3;
    #1;
    chk("ign_m_valid", 32'(m_valid), 0);
    chk("ign_busy", 32'(busy), 1);
    step();
    s_valid = 1'b1; s_data = 25'h0777001;
    step();
    cmd_dump = 1'b0; s_data = 25'h0777002;
    #1;
    chk("ign_still_load", 32'(s_ready), 1);
    step();
    s_valid = 1'b0;
    chk("ign_done", 32'(done), 1);
    step(); step();
    chk("ign_busy_after", 32'(busy), 0);
    chk("ign_done_count", 32'(done_cnt - done_mark), 1);
    chk("ign_mem1", 32'(mem[1]), 32'h0777002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
